// File: rtl/sumador_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing helper.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUMA  = 2'd1,
    LISTO = 2'd2
  } estadoT;

  // Width of the bit counter that steps 0..n-1.
  function automatic int cntWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sumador_completo_bit.sv
// Combinational 1-bit full adder built from two half adders and a carry OR.
module sumador_completo_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic haSum, haCarry, hbCarry;

  assign haSum   = a ^ b;
  assign haCarry = a & b;
  assign s       = haSum ^ cin;
  assign hbCarry = haSum & cin;
  assign cout    = haCarry | hbCarry;

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, carry fed back through a flip-flop.
module sumador_serial
  import sumador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int CntW = cntWidth(N);

  estadoT          stateReg, stateNext;
  logic [CntW-1:0] countReg, countNext;
  logic            carryReg, carryNext;
  logic            coutReg, coutNext;
  logic [N-1:0]    raReg, raNext;
  logic [N-1:0]    rbReg, rbNext;
  logic [N-1:0]    rsumReg, rsumNext;
  logic            bitS, bitC;

  sumador_completo_bit fa (
    .a   (raReg[0]),
    .b   (rbReg[0]),
    .cin (carryReg),
    .s   (bitS),
    .cout(bitC)
  );

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    carryNext = carryReg;
    coutNext  = coutReg;
    raNext    = raReg;
    rbNext    = rbReg;
    rsumNext  = rsumReg;
    unique case (stateReg)
      IDLE: begin
        if (in_valid) begin
          raNext    = a;
          rbNext    = b;
          carryNext = cin;
          countNext = '0;
          rsumNext  = '0;
          stateNext = SUMA;
        end
      end
      SUMA: begin
        // Sum bits enter at the MSB so bit 0 lands at rsum[0] after N shifts.
        rsumNext  = {bitS, rsumReg[N-1:1]};
        raNext    = {1'b0, raReg[N-1:1]};
        rbNext    = {1'b0, rbReg[N-1:1]};
        carryNext = bitC;
        countNext = countReg + 1'b1;
        if (countReg == CntW'(N - 1)) begin
          countNext = '0;
          coutNext  = bitC;
          stateNext = LISTO;
        end
      end
      LISTO: begin
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      countReg <= '0;
      carryReg <= 1'b0;
      coutReg  <= 1'b0;
      raReg    <= '0;
      rbReg    <= '0;
      rsumReg  <= '0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      carryReg <= carryNext;
      coutReg  <= coutNext;
      raReg    <= raNext;
      rbReg    <= rbNext;
      rsumReg  <= rsumNext;
    end
  end

  assign in_ready  = (stateReg == IDLE);
  assign out_valid = (stateReg == LISTO);
  assign sum       = rsumReg;
  assign cout      = coutReg;

endmodule
